// File: rtl/vec_vsetvl_unit.sv
// vec_vsetvl_unit: runs vsetvli/vsetivli/vsetvl, writes vl/vtype through the CSR regfile and returns vl to rd.
// Latency: accept T, CALC T+1, csrwr_en from T+2 until csr_done, rd_wr_en one cycle later, ready again after that.
// Backpressure: one instruction in flight; inst_ready low from accept until the RESP cycle has passed.
// Optional `VSETVL_AVL_SPLIT_EN: an AVL strictly between VLMAX and 2*VLMAX yields vl = ceil(AVL/2).
`ifndef XLEN
`define XLEN 32
`endif

module vec_vsetvl_unit #(
    parameter int VLEN = 512
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [`XLEN-1:0] inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [`XLEN-1:0] rs1_data,
    input  logic [`XLEN-1:0] rs2_data,
    input  logic [`XLEN-1:0] vec_length,
    output logic [`XLEN-1:0] scalar1,
    output logic [`XLEN-1:0] scalar2,
    output logic             csrwr_en,
    input  logic             csr_done,
    output logic [4:0]       rd_addr,
    output logic [`XLEN-1:0] rd_data,
    output logic             rd_wr_en,
    output logic             illegal_insn,
    output logic             illegal_vtype
);
    localparam int              XLEN   = `XLEN;
    localparam logic [6:0]      OPC_V  = 7'h57;
    localparam logic [XLEN-1:0] VLEN_X = XLEN'(VLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] avl_q, avl_d;
    logic [XLEN-1:0] vtype_q, vtype_d;
    logic [XLEN-1:0] scalar1_q, scalar1_d;
    logic [XLEN-1:0] scalar2_q, scalar2_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            illegal_insn_q, illegal_insn_d;
    logic            illegal_vtype_q, illegal_vtype_d;

    logic            is_opcfg, is_vsetvli, is_vsetivli, is_vsetvl, is_vset;
    logic [4:0]      dec_rd, dec_rs1;
    logic [XLEN-1:0] dec_vtype, dec_avl;

    logic            vtype_bad;
    logic [4:0]      sew_shift;
    logic [XLEN-1:0] vlmax, vl_min, vl_new;

    assign is_opcfg    = (inst[6:0] == OPC_V) && (inst[14:12] == 3'b111);
    assign is_vsetvli  = is_opcfg && !inst[31];
    assign is_vsetivli = is_opcfg && (inst[31:30] == 2'b11);
    assign is_vsetvl   = is_opcfg && (inst[31:25] == 7'b1000000);
    assign is_vset     = is_vsetvli || is_vsetivli || is_vsetvl;
    assign dec_rd      = inst[11:7];
    assign dec_rs1     = inst[19:15];

    always_comb begin
        dec_vtype = rs2_data;
        if (is_vsetvli) begin
            dec_vtype = {{(XLEN-11){1'b0}}, inst[30:20]};
        end else if (is_vsetivli) begin
            dec_vtype = {{(XLEN-10){1'b0}}, inst[29:20]};
        end

        // rs1=x0 with rd!=x0 requests VLMAX; with rd=x0 it keeps the current vl
        if (is_vsetivli) begin
            dec_avl = {{(XLEN-5){1'b0}}, dec_rs1};
        end else if (dec_rs1 != 5'd0) begin
            dec_avl = rs1_data;
        end else if (dec_rd != 5'd0) begin
            dec_avl = '1;
        end else begin
            dec_avl = vec_length;
        end
    end

    // Only integer LMUL and SEW up to 64 are supported; any bit above vma must be zero
    assign vtype_bad = (vtype_q[XLEN-1:8] != '0) || vtype_q[5] || vtype_q[2];
    assign sew_shift = {3'b000, vtype_q[4:3]} + 5'd3;
    assign vlmax     = (VLEN_X >> sew_shift) << vtype_q[1:0];
    assign vl_min    = (avl_q < vlmax) ? avl_q : vlmax;

`ifdef VSETVL_AVL_SPLIT_EN
    always_comb begin
        vl_new = vl_min;
        if ((avl_q > vlmax) && (avl_q < (vlmax << 1))) begin
            vl_new = (avl_q >> 1) + {{(XLEN-1){1'b0}}, avl_q[0]};
        end
    end
`else
    assign vl_new = vl_min;
`endif

    always_comb begin
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        avl_d           = avl_q;
        vtype_d         = vtype_q;
        scalar1_d       = scalar1_q;
        scalar2_d       = scalar2_q;
        rd_data_d       = rd_data_q;
        illegal_insn_d  = 1'b0;
        illegal_vtype_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    if (is_vset) begin
                        rd_addr_d = dec_rd;
                        avl_d     = dec_avl;
                        vtype_d   = dec_vtype;
                        state_d   = CALC;
                    end else begin
                        illegal_insn_d = 1'b1;
                    end
                end
            end
            CALC: begin
                if (vtype_bad) begin
                    illegal_vtype_d = 1'b1;
                    rd_data_d       = '0;
                    state_d         = RESP;
                end else begin
                    scalar1_d = vl_new;
                    scalar2_d = vtype_q;
                    rd_data_d = vl_new;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (csr_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            rd_addr_q       <= '0;
            avl_q           <= '0;
            vtype_q         <= '0;
            scalar1_q       <= '0;
            scalar2_q       <= '0;
            rd_data_q       <= '0;
            illegal_insn_q  <= 1'b0;
            illegal_vtype_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            avl_q           <= avl_d;
            vtype_q         <= vtype_d;
            scalar1_q       <= scalar1_d;
            scalar2_q       <= scalar2_d;
            rd_data_q       <= rd_data_d;
            illegal_insn_q  <= illegal_insn_d;
            illegal_vtype_q <= illegal_vtype_d;
        end
    end

    // csrwr_en drops in RESP so the regfile always sees a low cycle between writes
    assign inst_ready    = (state_q == IDLE);
    assign csrwr_en      = (state_q == WRITE);
    assign rd_wr_en      = (state_q == RESP) && (rd_addr_q != 5'd0);
    assign scalar1       = scalar1_q;
    assign scalar2       = scalar2_q;
    assign rd_addr       = rd_addr_q;
    assign rd_data       = rd_data_q;
    assign illegal_insn  = illegal_insn_q;
    assign illegal_vtype = illegal_vtype_q;

endmodule

// File: tb/tb_vec_vsetvl_unit.sv
// Bench for vec_vsetvl_unit: table of config instructions with hand-computed vl/vtype plus reset corner sequences.
`ifndef XLEN
`define XLEN 32
`endif

module tb_vec_vsetvl_unit;
    localparam int XLEN = `XLEN;

`ifdef VSETVL_AVL_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic [XLEN-1:0] inst = '0;
    logic            inst_valid = 1'b0;
    logic            inst_ready;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic [XLEN-1:0] vec_length = '0;
    logic [XLEN-1:0] scalar1;
    logic [XLEN-1:0] scalar2;
    logic            csrwr_en;
    logic            csr_done = 1'b0;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_wr_en;
    logic            illegal_insn;
    logic            illegal_vtype;

    always #5 clk = ~clk;

    vec_vsetvl_unit #(.VLEN(512)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .vec_length   (vec_length),
        .scalar1      (scalar1),
        .scalar2      (scalar2),
        .csrwr_en     (csrwr_en),
        .csr_done     (csr_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_wr_en     (rd_wr_en),
        .illegal_insn (illegal_insn),
        .illegal_vtype(illegal_vtype)
    );

    // Regfile stand-in: one csr_done pulse, one cycle after it first sees csrwr_en
    logic sample_wr = 1'b0;
    logic csr_sent = 1'b0;
    logic csr_resp_en = 1'b1;
    always @(negedge clk) sample_wr = csrwr_en;
    always @(posedge clk) begin
        #1;
        if (!sample_wr) csr_sent = 1'b0;
        csr_done = csr_resp_en && sample_wr && !csr_sent;
        if (csr_done) csr_sent = 1'b1;
    end

    typedef enum logic [1:0] {K_OK, K_BADVT, K_BADINSN} kind_e;
    typedef struct {
        logic [31:0]     inst;
        logic [XLEN-1:0] rs1_v;
        logic [XLEN-1:0] rs2_v;
        logic [XLEN-1:0] cur_vl;
        kind_e           kind;
        logic [XLEN-1:0] exp_vl;
        logic [XLEN-1:0] exp_vtype;
    } vec_t;
    typedef struct {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } rd_exp_t;
    typedef struct {
        logic [XLEN-1:0] vl;
        logic [XLEN-1:0] vtype;
    } csr_exp_t;

    vec_t     vecs[$];
    rd_exp_t  rd_q[$];
    csr_exp_t csr_q[$];
    int       tests = 0;
    int       failed = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_vli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] enc_vi(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] enc_vl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction
    function automatic vec_t mk(input logic [31:0] i, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                                input logic [XLEN-1:0] cvl, input kind_e k, input logic [XLEN-1:0] evl,
                                input logic [XLEN-1:0] evt);
        vec_t v;
        v.inst = i; v.rs1_v = r1; v.rs2_v = r2; v.cur_vl = cvl;
        v.kind = k; v.exp_vl = evl; v.exp_vtype = evt;
        return v;
    endfunction

    task automatic issue(input int id, input vec_t v);
        int       guard, f_wr, c_wr, f_rd, c_rd, f_rdy, f_iv, c_iv, f_ii, c_ii;
        logic [4:0] rd;
        csr_exp_t ce;
        rd_exp_t  re;
        rd = v.inst[11:7];
        guard = 0;
        @(negedge clk);
        while (!inst_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d ready_before_issue", id), 64'(inst_ready), 64'(1));
        if (v.kind == K_OK) begin
            ce.vl = v.exp_vl; ce.vtype = v.exp_vtype;
            csr_q.push_back(ce);
        end
        if (v.kind != K_BADINSN && rd != 5'd0) begin
            re.addr = rd;
            re.data = (v.kind == K_OK) ? v.exp_vl : '0;
            rd_q.push_back(re);
        end
        inst = XLEN'(v.inst); rs1_data = v.rs1_v; rs2_data = v.rs2_v; vec_length = v.cur_vl;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst = '0;
        f_wr = 0; c_wr = 0; f_rd = 0; c_rd = 0; f_rdy = 0; f_iv = 0; c_iv = 0; f_ii = 0; c_ii = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (csrwr_en) begin
                c_wr++;
                if (f_wr == 0) begin
                    f_wr = k;
                    check($sformatf("v%0d csr_expected", id), 64'(csr_q.size() != 0), 64'(1));
                    if (csr_q.size() != 0) begin
                        ce = csr_q.pop_front();
                        check($sformatf("v%0d scalar1", id), 64'(scalar1), 64'(ce.vl));
                        check($sformatf("v%0d scalar2", id), 64'(scalar2), 64'(ce.vtype));
                    end
                end
            end
            if (rd_wr_en) begin
                c_rd++;
                if (f_rd == 0) f_rd = k;
                check($sformatf("v%0d rd_expected", id), 64'(rd_q.size() != 0), 64'(1));
                if (rd_q.size() != 0) begin
                    re = rd_q.pop_front();
                    check($sformatf("v%0d rd_addr", id), 64'(rd_addr), 64'(re.addr));
                    check($sformatf("v%0d rd_data", id), 64'(rd_data), 64'(re.data));
                end
            end
            if (illegal_vtype) begin c_iv++; if (f_iv == 0) f_iv = k; end
            if (illegal_insn) begin c_ii++; if (f_ii == 0) f_ii = k; end
            if (inst_ready && f_rdy == 0) f_rdy = k;
        end
        check($sformatf("v%0d csrwr_first", id), 64'(f_wr), 64'((v.kind == K_OK) ? 2 : 0));
        check($sformatf("v%0d csrwr_cycles", id), 64'(c_wr), 64'((v.kind == K_OK) ? 2 : 0));
        check($sformatf("v%0d rdwr_first", id), 64'(f_rd),
              64'((v.kind == K_BADINSN || rd == 5'd0) ? 0 : ((v.kind == K_OK) ? 4 : 2)));
        check($sformatf("v%0d rdwr_cycles", id), 64'(c_rd), 64'((v.kind == K_BADINSN || rd == 5'd0) ? 0 : 1));
        check($sformatf("v%0d ready_again", id), 64'(f_rdy),
              64'((v.kind == K_OK) ? 5 : ((v.kind == K_BADVT) ? 3 : 1)));
        check($sformatf("v%0d illegal_vtype_first", id), 64'(f_iv), 64'((v.kind == K_BADVT) ? 2 : 0));
        check($sformatf("v%0d illegal_vtype_cycles", id), 64'(c_iv), 64'((v.kind == K_BADVT) ? 1 : 0));
        check($sformatf("v%0d illegal_insn_first", id), 64'(f_ii), 64'((v.kind == K_BADINSN) ? 1 : 0));
        check($sformatf("v%0d illegal_insn_cycles", id), 64'(c_ii), 64'((v.kind == K_BADINSN) ? 1 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("rst inst_ready", 64'(inst_ready), 64'(1));
        check("rst csrwr_en", 64'(csrwr_en), 64'(0));
        check("rst rd_wr_en", 64'(rd_wr_en), 64'(0));
        check("rst illegal", 64'({illegal_insn, illegal_vtype}), 64'(0));
        check("rst scalar1", 64'(scalar1), 64'(0));
        check("rst scalar2", 64'(scalar2), 64'(0));
        check("rst rd_data", 64'(rd_data), 64'(0));
        check("rst rd_addr", 64'(rd_addr), 64'(0));
        n_rst = 1'b1;

        vecs.push_back(mk(enc_vli(5'd1, 5'd5, 11'h010), 100, 0, 0, K_OK, 16, 'h10));
        vecs.push_back(mk(enc_vi(5'd2, 5'd5, 10'h009), 0, 0, 0, K_OK, 5, 'h09));
        vecs.push_back(mk(enc_vli(5'd3, 5'd0, 11'h01B), 123, 0, 7, K_OK, 64, 'h1B));
        vecs.push_back(mk(enc_vli(5'd0, 5'd0, 11'h010), 123, 0, 7, K_OK, 7, 'h10));
        vecs.push_back(mk(enc_vl(5'd4, 5'd6, 5'd7), 99, 'h28, 0, K_BADVT, 0, 0));
        vecs.push_back(mk(enc_vli(5'd5, 5'd6, 11'h010), 20, 0, 0, K_OK, SPLIT ? 10 : 16, 'h10));
        vecs.push_back(mk(32'h0000_0013, 0, 0, 0, K_BADINSN, 0, 0));
        vecs.push_back(mk(enc_vl(5'd6, 5'd7, 5'd8), 1000, 'h00, 0, K_OK, 64, 'h00));
        vecs.push_back(mk(enc_vli(5'd7, 5'd8, 11'h003), 5000, 0, 0, K_OK, 512, 'h03));
        vecs.push_back(mk(enc_vli(5'd8, 5'd9, 11'h010), 32, 0, 0, K_OK, 16, 'h10));
        vecs.push_back(mk(enc_vli(5'd9, 5'd9, 11'h010), 17, 0, 0, K_OK, SPLIT ? 9 : 16, 'h10));
        vecs.push_back(mk(enc_vli(5'd10, 5'd1, 11'h014), 10, 0, 0, K_BADVT, 0, 0));
        vecs.push_back(mk(enc_vl(5'd11, 5'd1, 5'd2), 10, 'h110, 0, K_BADVT, 0, 0));
        vecs.push_back(mk(enc_vli(5'd12, 5'd3, 11'h0D0), 3, 0, 0, K_OK, 3, 'hD0));
        vecs.push_back(mk({7'b1000001, 5'd2, 5'd3, 3'b111, 5'd1, 7'h57}, 0, 0, 0, K_BADINSN, 0, 0));
        vecs.push_back(mk({1'b0, 11'h010, 5'd5, 3'b000, 5'd1, 7'h57}, 0, 0, 0, K_BADINSN, 0, 0));
        vecs.push_back(mk(enc_vi(5'd0, 5'd31, 10'h000), 0, 0, 0, K_OK, 31, 'h00));
        vecs.push_back(mk(enc_vi(5'd13, 5'd0, 10'h010), 0, 0, 0, K_OK, 0, 'h10));

        foreach (vecs[i]) issue(i, vecs[i]);

        // Reset while WRITE waits on a withheld csr_done
        csr_resp_en = 1'b0;
        @(negedge clk);
        inst = XLEN'(vecs[0].inst); rs1_data = vecs[0].rs1_v; rs2_data = '0; vec_length = '0;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst = '0;
        repeat (5) @(negedge clk);
        check("rstmid csrwr_held", 64'(csrwr_en), 64'(1));
        check("rstmid busy", 64'(inst_ready), 64'(0));
        n_rst = 1'b0;
        #1;
        check("rstmid csrwr_en", 64'(csrwr_en), 64'(0));
        check("rstmid inst_ready", 64'(inst_ready), 64'(1));
        check("rstmid rd_wr_en", 64'(rd_wr_en), 64'(0));
        check("rstmid scalar1", 64'(scalar1), 64'(0));
        @(negedge clk);
        n_rst = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_wr_en || csrwr_en) cnt++;
        end
        check("rstmid no_activity_after", 64'(cnt), 64'(0));
        csr_resp_en = 1'b1;
        issue(99, vecs[0]);

        check("csr_q drained", 64'(csr_q.size()), 64'(0));
        check("rd_q drained", 64'(rd_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
